// File: rtl/fetch_pkg.sv
// Shared types for the fetch PC generator: FSM states, delivered-instruction record,
// and the sequential-PC helper.
package fetch_pkg;

  typedef enum logic [1:0] {BOOT, RUN, WAIT} fetch_state_t;

  localparam int unsigned INSTR_BYTES = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_inst_t;

  // Wraps modulo 2^32 by construction; no overflow indication is wanted.
  function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
    return pc + 32'(INSTR_BYTES);
  endfunction

endpackage

// File: rtl/fetch_pc_gen_if.sv
// Branch-resolution, IMEM and decode-side signals of the fetch stage.
// master = fetch stage, slave = surrounding pipeline/memory.
interface fetch_pc_gen_if;

  logic        io_brValid;
  logic        io_brTaken;
  logic [31:0] io_brTarget;
  logic        io_brMisaligned;
  logic        io_fetchReq;
  logic [31:0] io_fetchAddr;
  logic        io_fetchReady;
  logic        io_fetchRespValid;
  logic [31:0] io_fetchRespInstr;
  logic        io_instValid;
  logic [31:0] io_instPc;
  logic [31:0] io_instWord;
  logic        io_deqReady;
  logic        io_flush;
  logic        io_trap;
  logic [31:0] io_trapPc;

  modport master (
    input  io_brValid, io_brTaken, io_brTarget, io_brMisaligned,
    output io_fetchReq, io_fetchAddr,
    input  io_fetchReady, io_fetchRespValid, io_fetchRespInstr,
    output io_instValid, io_instPc, io_instWord,
    input  io_deqReady,
    output io_flush, io_trap, io_trapPc
  );

  modport slave (
    output io_brValid, io_brTaken, io_brTarget, io_brMisaligned,
    input  io_fetchReq, io_fetchAddr,
    output io_fetchReady, io_fetchRespValid, io_fetchRespInstr,
    input  io_instValid, io_instPc, io_instWord,
    output io_deqReady,
    input  io_flush, io_trap, io_trapPc
  );

endinterface

// File: rtl/fetch_skid_reg.sv
// One-entry valid/ready holding register between IMEM response and decode.
// A flush discards the held entry.
module fetch_skid_reg
  import fetch_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  input  fetch_inst_t in_data,
  output logic        out_valid,
  output fetch_inst_t out_data,
  input  logic        out_ready
);

  logic        valid_q;
  fetch_inst_t data_q;

  // The producer only writes when the entry is empty or draining, so a load never clobbers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (in_valid) begin
      valid_q <= 1'b1;
      data_q  <= in_data;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = valid_q ? data_q : '0;

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: one-outstanding IMEM fetch, redirect/trap squash, delivery to decode.
// Define FETCH_SKID_EN to register delivered instructions in a 1-entry skid register.
module fetch_pc_gen
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC  = 32'h0000_0100
) (
  input  logic          clock,
  input  logic          reset,
  fetch_pc_gen_if.master bus
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_pc_q, req_pc_d;
  logic         stale_q, stale_d;
  logic         flush_q, trap_q;
  logic [31:0]  trap_pc_q;

  logic take_trap, take_redirect, redir_any;
  logic can_issue, fetch_req, resp_deliver;

  assign take_trap     = bus.io_brValid & bus.io_brMisaligned;
  assign take_redirect = bus.io_brValid & bus.io_brTaken & ~bus.io_brMisaligned;
  assign redir_any     = take_trap | take_redirect;

  // Next-state logic; a redirect/trap overrides whatever sequential PC the FSM chose.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    stale_d      = stale_q;
    fetch_req    = 1'b0;
    resp_deliver = 1'b0;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        fetch_req = can_issue;
        if (fetch_req && bus.io_fetchReady) begin
          state_d  = WAIT;
          req_pc_d = pc_q;
          stale_d  = redir_any;
        end
      end
      WAIT: begin
        if (bus.io_fetchRespValid) begin
          state_d      = RUN;
          stale_d      = 1'b0;
          resp_deliver = ~stale_q & ~redir_any;
          if (resp_deliver) pc_d = next_seq_pc(req_pc_q);
        end else if (redir_any) begin
          stale_d = 1'b1;
        end
      end
      default: state_d = BOOT;
    endcase
    if (take_trap)          pc_d = TRAP_VEC;
    else if (take_redirect) pc_d = bus.io_brTarget;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= BOOT;
      pc_q      <= RESET_VEC;
      req_pc_q  <= '0;
      stale_q   <= 1'b0;
      flush_q   <= 1'b0;
      trap_q    <= 1'b0;
      trap_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      stale_q  <= stale_d;
      flush_q  <= redir_any;
      trap_q   <= take_trap;
      if (take_trap) trap_pc_q <= bus.io_brTarget;
    end
  end

  assign bus.io_fetchReq  = fetch_req;
  assign bus.io_fetchAddr = fetch_req ? pc_q : '0;
  assign bus.io_flush     = flush_q;
  assign bus.io_trap      = trap_q;
  assign bus.io_trapPc    = trap_pc_q;

`ifdef FETCH_SKID_EN
  fetch_inst_t skid_in, skid_out;
  logic        skid_valid;

  assign skid_in   = '{pc: req_pc_q, instr: bus.io_fetchRespInstr};
  assign can_issue = ~skid_valid | bus.io_deqReady;

  fetch_skid_reg u_skid (
    .clock     (clock),
    .reset     (reset),
    .flush     (redir_any),
    .in_valid  (resp_deliver),
    .in_data   (skid_in),
    .out_valid (skid_valid),
    .out_data  (skid_out),
    .out_ready (bus.io_deqReady)
  );

  assign bus.io_instValid = skid_valid;
  assign bus.io_instPc    = skid_out.pc;
  assign bus.io_instWord  = skid_out.instr;
`else
  // Pass-through delivery relies on decode holding io_deqReady from request to response.
  assign can_issue        = bus.io_deqReady;
  assign bus.io_instValid = resp_deliver;
  assign bus.io_instPc    = resp_deliver ? req_pc_q : '0;
  assign bus.io_instWord  = resp_deliver ? bus.io_fetchRespInstr : '0;
`endif

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed bench for fetch_pc_gen (default build): per-cycle vector table plus a
// hand-written reset-during-WAIT sequence.
module tb_fetch_pc_gen;

  typedef struct {
    logic        bv, bt, bm;
    logic [31:0] tgt;
    logic        fr, rv;
    logic [31:0] ri;
    logic        dr;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_iv;
    logic [31:0] exp_pc, exp_word;
    logic        exp_flush, exp_trap;
    logic [31:0] exp_tpc;
  } vec_t;

  logic clock;
  logic reset;
  int   tests_run;
  int   tests_failed;
  vec_t vecs[$];

  fetch_pc_gen_if bus ();

  fetch_pc_gen dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic vec_t mk(input logic bv, bt, bm, input logic [31:0] tgt,
                              input logic fr, rv, input logic [31:0] ri, input logic dr,
                              input logic er, input logic [31:0] ea, input logic eiv,
                              input logic [31:0] epc, ew, input logic efl, etr,
                              input logic [31:0] etpc);
    vec_t v;
    v.bv = bv; v.bt = bt; v.bm = bm; v.tgt = tgt;
    v.fr = fr; v.rv = rv; v.ri = ri; v.dr = dr;
    v.exp_req = er; v.exp_addr = ea; v.exp_iv = eiv; v.exp_pc = epc; v.exp_word = ew;
    v.exp_flush = efl; v.exp_trap = etr; v.exp_tpc = etpc;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    bus.io_brValid        = v.bv;
    bus.io_brTaken        = v.bt;
    bus.io_brMisaligned   = v.bm;
    bus.io_brTarget       = v.tgt;
    bus.io_fetchReady     = v.fr;
    bus.io_fetchRespValid = v.rv;
    bus.io_fetchRespInstr = v.ri;
    bus.io_deqReady       = v.dr;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic checkVector(input int idx, input vec_t v);
    checkOutput($sformatf("v%0d fetchReq", idx), 32'(bus.io_fetchReq), 32'(v.exp_req));
    if (v.exp_req) checkOutput($sformatf("v%0d fetchAddr", idx), bus.io_fetchAddr, v.exp_addr);
    checkOutput($sformatf("v%0d instValid", idx), 32'(bus.io_instValid), 32'(v.exp_iv));
    if (v.exp_iv) begin
      checkOutput($sformatf("v%0d instPc", idx), bus.io_instPc, v.exp_pc);
      checkOutput($sformatf("v%0d instWord", idx), bus.io_instWord, v.exp_word);
    end
    checkOutput($sformatf("v%0d flush", idx), 32'(bus.io_flush), 32'(v.exp_flush));
    checkOutput($sformatf("v%0d trap", idx), 32'(bus.io_trap), 32'(v.exp_trap));
    checkOutput($sformatf("v%0d trapPc", idx), bus.io_trapPc, v.exp_tpc);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;

    //          bv bt bm target        fr rv instr         dr | req addr          iv pc            word          fl tr trapPc
    vecs.push_back(mk(0,0,0,32'h0,        1,0,32'h0,        1,  0,32'h0,         0,32'h0,        32'h0,        0,0,32'h0));   // BOOT
    vecs.push_back(mk(0,0,0,32'h0,        1,0,32'h0,        1,  1,32'h0,         0,32'h0,        32'h0,        0,0,32'h0));
    vecs.push_back(mk(0,0,0,32'h0,        1,1,32'hA000_0000,1,  0,32'h0,         1,32'h0,        32'hA000_0000,0,0,32'h0));
    vecs.push_back(mk(1,0,0,32'h300,      1,0,32'h0,        1,  1,32'h4,         0,32'h0,        32'h0,        0,0,32'h0));   // not-taken branch
    vecs.push_back(mk(0,0,0,32'h0,        1,1,32'hA000_0004,1,  0,32'h0,         1,32'h4,        32'hA000_0004,0,0,32'h0));
    vecs.push_back(mk(0,0,0,32'h0,        1,0,32'h0,        1,  1,32'h8,         0,32'h0,        32'h0,        0,0,32'h0));
    vecs.push_back(mk(0,0,0,32'h0,        1,1,32'hA000_0008,1,  0,32'h0,         1,32'h8,        32'hA000_0008,0,0,32'h0));
    vecs.push_back(mk(0,0,0,32'h0,        1,0,32'h0,        1,  1,32'hC,         0,32'h0,        32'h0,        0,0,32'h0));
    vecs.push_back(mk(0,0,0,32'h0,        1,0,32'h0,        1,  0,32'h0,         0,32'h0,        32'h0,        0,0,32'h0));   // WAIT
    vecs.push_back(mk(0,0,0,32'h0,        1,0,32'h0,        1,  0,32'h0,         0,32'h0,        32'h0,        0,0,32'h0));
    vecs.push_back(mk(1,1,0,32'h200,      1,0,32'h0,        1,  0,32'h0,         0,32'h0,        32'h0,        0,0,32'h0));   // redirect in WAIT
    vecs.push_back(mk(0,0,0,32'h0,        1,1,32'hDEAD_0000,1,  0,32'h0,         0,32'h0,        32'h0,        1,0,32'h0));   // stale resp dropped
    vecs.push_back(mk(0,0,0,32'h0,        1,0,32'h0,        1,  1,32'h200,       0,32'h0,        32'h0,        0,0,32'h0));
    vecs.push_back(mk(0,0,0,32'h0,        1,1,32'hB000_0200,1,  0,32'h0,         1,32'h200,      32'hB000_0200,0,0,32'h0));
    vecs.push_back(mk(1,1,1,32'h202,      0,0,32'h0,        1,  1,32'h204,       0,32'h0,        32'h0,        0,0,32'h0));   // trap
    vecs.push_back(mk(0,0,0,32'h0,        1,0,32'h0,        1,  1,32'h100,       0,32'h0,        32'h0,        1,1,32'h202));
    vecs.push_back(mk(0,0,0,32'h0,        1,1,32'hC000_0100,1,  0,32'h0,         1,32'h100,      32'hC000_0100,0,0,32'h202));
    vecs.push_back(mk(0,0,0,32'h0,        1,0,32'h0,        1,  1,32'h104,       0,32'h0,        32'h0,        0,0,32'h202));
    vecs.push_back(mk(1,1,0,32'h40,       1,1,32'hDEAD_0001,1,  0,32'h0,         0,32'h0,        32'h0,        0,0,32'h202)); // resp + redirect
    vecs.push_back(mk(0,0,0,32'h0,        1,0,32'h0,        1,  1,32'h40,        0,32'h0,        32'h0,        1,0,32'h202));
    vecs.push_back(mk(0,0,0,32'h0,        1,1,32'hE000_0040,1,  0,32'h0,         1,32'h40,       32'hE000_0040,0,0,32'h202));
    vecs.push_back(mk(1,1,0,32'h80,       1,0,32'h0,        1,  1,32'h44,        0,32'h0,        32'h0,        0,0,32'h202)); // redirect on accept
    vecs.push_back(mk(0,0,0,32'h0,        1,1,32'hDEAD_0002,1,  0,32'h0,         0,32'h0,        32'h0,        1,0,32'h202));
    vecs.push_back(mk(0,0,0,32'h0,        1,0,32'h0,        1,  1,32'h80,        0,32'h0,        32'h0,        0,0,32'h202));
    vecs.push_back(mk(0,0,0,32'h0,        1,1,32'h0000_0008,1,  0,32'h0,         1,32'h80,       32'h0000_0008,0,0,32'h202));
    vecs.push_back(mk(1,1,0,32'hFFFF_FFFC,0,0,32'h0,        1,  1,32'h84,        0,32'h0,        32'h0,        0,0,32'h202));
    vecs.push_back(mk(0,0,0,32'h0,        1,0,32'h0,        1,  1,32'hFFFF_FFFC, 0,32'h0,        32'h0,        1,0,32'h202));
    vecs.push_back(mk(0,0,0,32'h0,        1,1,32'hF000_FFFC,1,  0,32'h0,         1,32'hFFFF_FFFC,32'hF000_FFFC,0,0,32'h202));
    vecs.push_back(mk(0,0,0,32'h0,        0,0,32'h0,        1,  1,32'h0,         0,32'h0,        32'h0,        0,0,32'h202)); // wrapped PC
    vecs.push_back(mk(0,0,0,32'h0,        1,0,32'h0,        1,  1,32'h0,         0,32'h0,        32'h0,        0,0,32'h202));
    vecs.push_back(mk(0,0,0,32'h0,        1,1,32'h1111_0000,1,  0,32'h0,         1,32'h0,        32'h1111_0000,0,0,32'h202));
    vecs.push_back(mk(0,0,0,32'h0,        1,0,32'h0,        0,  0,32'h0,         0,32'h0,        32'h0,        0,0,32'h202)); // decode not ready
    vecs.push_back(mk(0,0,0,32'h0,        1,0,32'h0,        1,  1,32'h4,         0,32'h0,        32'h0,        0,0,32'h202)); // enter WAIT

    reset = 1'b0;
    applyStimulus(vecs[0]);
    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset fetchReq",  32'(bus.io_fetchReq),  32'h0);
    checkOutput("reset instValid", 32'(bus.io_instValid), 32'h0);
    checkOutput("reset flush",     32'(bus.io_flush),     32'h0);
    checkOutput("reset trapPc",    bus.io_trapPc,         32'h0);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      @(negedge clock);
      checkVector(i, vecs[i]);
      @(posedge clock);
      #1;
    end

    // Asynchronous reset while a fetch is outstanding at 0x4.
    bus.io_fetchRespValid = 1'b1;
    bus.io_fetchRespInstr = 32'h5555_AAAA;
    @(negedge clock);
    reset = 1'b0;
    #1;
    checkOutput("wait-reset fetchReq",  32'(bus.io_fetchReq),  32'h0);
    checkOutput("wait-reset fetchAddr", bus.io_fetchAddr,      32'h0);
    checkOutput("wait-reset instValid", 32'(bus.io_instValid), 32'h0);
    checkOutput("wait-reset flush",     32'(bus.io_flush),     32'h0);
    checkOutput("wait-reset trap",      32'(bus.io_trap),      32'h0);
    checkOutput("wait-reset trapPc",    bus.io_trapPc,         32'h0);
    bus.io_fetchRespValid = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(negedge clock);
    checkOutput("post-reset boot fetchReq", 32'(bus.io_fetchReq), 32'h0);
    @(posedge clock);
    #1;
    @(negedge clock);
    checkOutput("post-reset fetchReq",  32'(bus.io_fetchReq), 32'h1);
    checkOutput("post-reset fetchAddr", bus.io_fetchAddr,     32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
